rotating_square_gen: RTL and testbench
======================================

// Module: rotating_square_gen
// PURPOSE
//  Parametrised rotating-square animation for an N-digit multiplexed 7-seg display.
//  A single square travels in a closed loop: upper squares across all digits, then lower squares back.
//  Adds programmable speed, bounce (ping-pong) mode and a position output.
//  Sits between board top level (switches/buttons) and the active-low anode/segment pins.
// PARAMETERS
//  N_DIGITS     4           number of digits, 2..8
//  STEP_DIV     25_000_000  clk cycles per animation step at speed=0; must be >= 8
//  REFRESH_DIV  100_000     clk cycles each digit is driven during scanning; >= 1
//  POS_W        $clog2(2*N_DIGITS)  width of pos (localparam)
// PORTS
//  clk      in   1         system clock, all logic rising-edge
//  reset    in   1         asynchronous, active-high
//  en       in   1         1 = animation advances; 0 = frozen (scanning continues)
//  cw       in   1         direction in wrap mode (1 = pos increments); seeds bounce direction
//  bounce   in   1         0 = wrap mode, 1 = ping-pong between pos 0 and 2N-1
//  speed    in   2         step period = STEP_DIV >> speed (speed=3 is 8x faster)
//  an       out  N_DIGITS  active-low one-hot digit enable; an[0] = rightmost digit
//  segment  out  8         {dp,g,f,e,d,c,b,a}, active low
//  pos      out  POS_W     current square position 0..2N-1
// BEHAVIOUR
//  Reset: pos=0, dir_r=1, step_cnt=0, scan_cnt=0, digit_sel=0, an=~1 (digit 0), segment=8'hFF.
//  Position map: p<N -> upper square (a,b,f,g: seg[6:0]=7'b0011100) on digit N-1-p;
//   p>=N -> lower square (c,d,e,g: seg[6:0]=7'b0100011) on digit p-N. All other digits blank 7'h7F. dp always 1.
//  Step timer: period P = STEP_DIV >> speed. While en=1, step_cnt increments; when step_cnt >= P-1
//   a step fires that cycle and step_cnt clears to 0 (>= compare: speed change mid-count never stalls).
//   en=0 holds step_cnt and pos unchanged.
//  Wrap mode (bounce=0): step with cw=1 -> pos = (pos==2N-1) ? 0 : pos+1; cw=0 -> pos = (pos==0) ? 2N-1 : pos-1.
//   cw sampled the cycle of the step; dir_r <= cw every cycle in wrap mode.
//  Bounce mode (bounce=1): direction from dir_r (1 = up). On step: if dir_r=1 and pos==2N-1 -> dir_r<=0, pos<=2N-2;
//   if dir_r=0 and pos==0 -> dir_r<=1, pos<=1; else pos moves one in dir_r. cw ignored while bounce=1.
//   Entering bounce mode continues from current pos with dir_r = last cw.
//  pos updates on the clock edge of the step; an/segment reflect new pos no later than the next edge.
//  Scanning: scan_cnt counts 0..REFRESH_DIV-1; at terminal count digit_sel advances (wraps N-1 -> 0).
//   an and segment are registered: an = ~(1<<digit_sel); segment = pattern for digit_sel. Independent of en.
//  Reset asserted mid-step or mid-scan: all state returns to reset values immediately (async), no glitch
//   beyond the registered outputs; first step fires P cycles after reset release with en=1.
//  Never more than one anode low; never an anode low with undefined segment value.
// TESTING  (sim params: N_DIGITS=4, STEP_DIV=8, REFRESH_DIV=2)
//  1. reset held, then released, en=0 for 100 cycles -> pos=0; an cycles 1110,1101,1011,0111 every 2 clks;
//     segment=8'b10011100 only while an=0111 (digit 3), else 8'hFF.
//  2. en=1,cw=1,speed=0 -> pos 0..7 stepping every 8 clks, 7->0 wrap; pos=4 shows lower square (8'b10100011) on digit 0.
//  3. en=1,cw=0 from pos=0 -> next step pos=7, then 6; toggle cw mid-period -> direction follows at next step only.
//  4. bounce=1,cw=1 from pos=5 -> 6,7,6,5..0,1,2: no repeat of endpoints, no wrap; cw changes ignored.
//  5. speed=3 (P=1) -> pos changes every clk; switch speed 0->3 with step_cnt=6 -> step next clk, cnt=0.
//  6. assert reset asynchronously mid-animation (pos=5, step_cnt=3) -> pos=0, an=4'b1110, segment=8'hFF
//     before next clk edge; en=0 toggling never alters an scanning rate.

Source files
------------

// File: rtl/rotating_square_gen.sv
// Rotating-square animation for an N-digit multiplexed 7-segment display.
// A step timer moves the square (wrap or ping-pong), and a scan timer multiplexes the digits.
module rotating_square_gen #(
    parameter int N_DIGITS    = 4,
    parameter int STEP_DIV    = 25_000_000,
    parameter int REFRESH_DIV = 100_000,
    localparam int POS_W      = $clog2(2 * N_DIGITS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                cw,
    input  logic                bounce,
    input  logic [1:0]          speed,
    output logic [N_DIGITS-1:0] an,
    output logic [7:0]          segment,
    output logic [POS_W-1:0]    pos
);

    localparam int STEP_W = $clog2(STEP_DIV);
    localparam int SCAN_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DSEL_W = $clog2(N_DIGITS);

    localparam logic [POS_W-1:0]  POS_MAX   = POS_W'(2 * N_DIGITS - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_DIV - 1);
    localparam logic [DSEL_W-1:0] DSEL_LAST = DSEL_W'(N_DIGITS - 1);

    localparam logic [7:0] SEG_UPPER = 8'b1001_1100;
    localparam logic [7:0] SEG_LOWER = 8'b1010_0011;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    logic [STEP_W-1:0] step_cnt;
    logic [STEP_W-1:0] step_last;
    logic              step_fire;
    logic              dir_r;
    logic              dir_nxt;
    logic [POS_W-1:0]  pos_nxt;
    logic [SCAN_W-1:0] scan_cnt;
    logic [DSEL_W-1:0] digit_sel;

    function automatic logic [7:0] digit_pattern(input logic [DSEL_W-1:0] d,
                                                 input logic [POS_W-1:0]  p);
        int di;
        int pi;
        logic [7:0] seg;
        di  = int'(d);
        pi  = int'(p);
        seg = SEG_BLANK;
        if (pi < N_DIGITS) begin
            if (di == N_DIGITS - 1 - pi)
                seg = SEG_UPPER;
        end else if (di == pi - N_DIGITS) begin
            seg = SEG_LOWER;
        end
        return seg;
    endfunction

    // >= compare so a shorter period picked mid-count fires at once instead of stalling
    always_comb begin
        step_last = STEP_W'((STEP_DIV >> speed) - 1);
        step_fire = en && (step_cnt >= step_last);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_cnt <= '0;
        end else if (en) begin
            if (step_fire)
                step_cnt <= '0;
            else
                step_cnt <= step_cnt + 1'b1;
        end
    end

    always_comb begin
        pos_nxt = pos;
        dir_nxt = dir_r;
        if (!bounce) begin
            dir_nxt = cw;
            if (step_fire) begin
                if (cw)
                    pos_nxt = (pos == POS_MAX) ? '0 : pos + 1'b1;
                else
                    pos_nxt = (pos == '0) ? POS_MAX : pos - 1'b1;
            end
        end else if (step_fire) begin
            if (dir_r) begin
                if (pos == POS_MAX) begin
                    dir_nxt = 1'b0;
                    pos_nxt = POS_MAX - 1'b1;
                end else begin
                    pos_nxt = pos + 1'b1;
                end
            end else begin
                if (pos == '0) begin
                    dir_nxt = 1'b1;
                    pos_nxt = POS_W'(1);
                end else begin
                    pos_nxt = pos - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos   <= '0;
            dir_r <= 1'b1;
        end else begin
            pos   <= pos_nxt;
            dir_r <= dir_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt  <= '0;
            digit_sel <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            digit_sel <= (digit_sel == DSEL_LAST) ? '0 : digit_sel + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Anode and segment come from the same digit_sel so they always change together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an      <= ~N_DIGITS'(1);
            segment <= SEG_BLANK;
        end else begin
            an      <= ~(N_DIGITS'(1) << digit_sel);
            segment <= digit_pattern(digit_sel, pos);
        end
    end

endmodule

// File: tb/tb_rotating_square_gen.sv
// Directed bench for rotating_square_gen with N_DIGITS=4, STEP_DIV=8, REFRESH_DIV=2.
module tb_rotating_square_gen;

    logic       clk;
    logic       reset;
    logic       en;
    logic       cw;
    logic       bounce;
    logic [1:0] speed;
    logic [3:0] an;
    logic [7:0] segment;
    logic [2:0] pos;

    int total  = 0;
    int passed = 0;

    rotating_square_gen #(
        .N_DIGITS    (4),
        .STEP_DIV    (8),
        .REFRESH_DIV (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .cw      (cw),
        .bounce  (bounce),
        .speed   (speed),
        .an      (an),
        .segment (segment),
        .pos     (pos)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected segment byte for digit d with the square at position p (4 digits)
    function automatic logic [7:0] exp_seg(input int d, input int p);
        if (p < 4 && d == 3 - p) return 8'b1001_1100;
        if (p >= 4 && d == p - 4) return 8'b1010_0011;
        return 8'hFF;
    endfunction

    function automatic logic [3:0] exp_an(input int d);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << d);
    endfunction

    task automatic check_display(input int d, input logic [7:0] seg_exp);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            check("an_onehot", 32'($countones(~an)), 32'd1);
            if (an == exp_an(d)) begin
                check("disp_seg", {24'd0, segment}, {24'd0, seg_exp});
                found = 1'b1;
            end
        end
        if (!found) begin
            total++;
            $error("FAIL disp_timeout: observed no anode for digit %0d required within 12 clks", d);
        end
    endtask

    int exp_bounce [10] = '{7, 6, 5, 4, 3, 2, 1, 0, 1, 2};

    initial begin
        reset  = 1'b0;
        en     = 1'b0;
        cw     = 1'b1;
        bounce = 1'b0;
        speed  = 2'd0;
        #2 reset = 1'b1;
        #2;
        check("rst_pos", 32'(pos), 32'd0);
        check("rst_an", 32'(an), 32'b1110);
        check("rst_seg", 32'(segment), 32'hFF);
        repeat (3) tick();
        reset = 1'b0;

        // Frozen animation: scanning only, square on digit 3
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("t1_an", 32'(an), 32'(exp_an(((k - 1) / 2) % 4)));
            check("t1_seg", 32'(segment), 32'(exp_seg(((k - 1) / 2) % 4, 0)));
            check("t1_pos", 32'(pos), 32'd0);
        end

        // Wrap mode, cw=1: first step lands P clocks after enabling
        en = 1'b1;
        repeat (7) tick();
        check("t2_first_hold", 32'(pos), 32'd0);
        tick();
        check("t2_first_step", 32'(pos), 32'd1);
        for (int p = 2; p <= 7; p++) begin
            repeat (8) tick();
            check("t2_step", 32'(pos), 32'(p));
            if (p == 4) begin
                en = 1'b0;
                check_display(0, 8'b1010_0011);
                check_display(3, 8'hFF);
                en = 1'b1;
            end
        end
        repeat (8) tick();
        check("t2_wrap", 32'(pos), 32'd0);

        // Wrap mode, cw=0, and a mid-period direction change
        cw = 1'b0;
        repeat (8) tick();
        check("t3_wrap_down", 32'(pos), 32'd7);
        repeat (8) tick();
        check("t3_down", 32'(pos), 32'd6);
        repeat (4) tick();
        cw = 1'b1;
        repeat (3) tick();
        check("t3_hold", 32'(pos), 32'd6);
        tick();
        check("t3_follow_up", 32'(pos), 32'd7);
        repeat (3) tick();
        cw = 1'b0;
        repeat (4) tick();
        check("t3_hold2", 32'(pos), 32'd7);
        tick();
        check("t3_follow_down", 32'(pos), 32'd6);
        repeat (8) tick();
        check("t3_to5", 32'(pos), 32'd5);

        // Bounce mode from pos 5 heading up; cw toggles must be ignored
        cw = 1'b1;
        tick();
        bounce = 1'b1;
        repeat (7) tick();
        check("t4_first", 32'(pos), 32'd6);
        for (int i = 0; i < 10; i++) begin
            cw = ~cw;
            repeat (8) tick();
            check("t4_bounce", 32'(pos), 32'(exp_bounce[i]));
        end

        // Speed: P=1 steps every clock, then speed raised with step_cnt=6
        bounce = 1'b0;
        cw     = 1'b1;
        speed  = 2'd3;
        for (int p = 3; p <= 8; p++) begin
            tick();
            check("t5_fast", 32'(pos), 32'(p % 8));
        end
        speed = 2'd0;
        repeat (6) tick();
        check("t5_cnt6_hold", 32'(pos), 32'd0);
        speed = 2'd3;
        tick();
        check("t5_switch_step", 32'(pos), 32'd1);
        speed = 2'd1;
        repeat (3) tick();
        check("t5_p4_hold", 32'(pos), 32'd1);
        tick();
        check("t5_p4_step", 32'(pos), 32'd2);

        // Asynchronous reset at pos=5, step_cnt=3
        speed = 2'd0;
        repeat (24) tick();
        check("t6_pre_pos", 32'(pos), 32'd5);
        repeat (3) tick();
        #2 reset = 1'b1;
        #1;
        check("t6_async_pos", 32'(pos), 32'd0);
        check("t6_async_an", 32'(an), 32'b1110);
        check("t6_async_seg", 32'(segment), 32'hFF);
        #2 reset = 1'b0;
        en = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("t6_scan_rate", 32'(an), 32'(exp_an(((k - 1) / 2) % 4)));
            if (k % 3 == 0) en = ~en;
        end

        // First step after reset release with en=1
        reset = 1'b1;
        en    = 1'b1;
        cw    = 1'b1;
        #2 reset = 1'b0;
        repeat (7) tick();
        check("t6_post_hold", 32'(pos), 32'd0);
        tick();
        check("t6_post_step", 32'(pos), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
